regfile_banked_pc: RTL

- Parametrised successor of the CPU datapath register file: NUM_REGS x DATA_W general registers, three combinational read ports (Rn, Rm, Rs), one synchronous write port.
- Adds a dedicated PC with load, auto-increment and write-by-index; optional write-to-read bypass; a per-register pending-load scoreboard that raises hazard flags to the control unit.
- Sits between the decode/control unit and the ALU/shifter.

---
 rtl/rf_pkg.sv | 19 +
 rtl/regfile_banked_pc_if.sv | 52 +++++
 rtl/rf_scoreboard.sv | 62 ++++++
 rtl/regfile_banked_pc.sv | 106 ++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared defaults and helpers for the banked register file with dedicated PC.
package rf_pkg;

    localparam int DEF_DATA_W       = 32;
    localparam int DEF_NUM_REGS     = 16;
    localparam int DEF_PC_STEP      = 4;
    localparam int DEF_PC_READ_OFS  = 8;
    localparam int DEF_RESET_VECTOR = 0;

    // Value seen when the PC index is read through a read port: the pipeline
    // exposes the PC a fixed distance ahead of the raw fetch address. The
    // caller truncates the 64-bit sum to its own width, so DATA_W must be 64
    // or less.
    function automatic logic [63:0] pc_read_value(input logic [63:0] pc,
                                                  input logic [63:0] ofs);
        return pc + ofs;
    endfunction

endpackage

// File: rtl/regfile_banked_pc_if.sv
// Bus between the decode/control unit (master) and the register file (slave).
interface regfile_banked_pc_if
    import rf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = $clog2(DEF_NUM_REGS)
);
    // Write port
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    // Read ports
    logic [ADDR_W-1:0] rd_addr_n;
    logic [ADDR_W-1:0] rd_addr_m;
    logic [ADDR_W-1:0] rd_addr_s;
    logic [DATA_W-1:0] rd_n;
    logic [DATA_W-1:0] rd_m;
    logic [DATA_W-1:0] rd_s;
    // PC control
    logic              pc_load;
    logic [DATA_W-1:0] pc_in;
    logic              pc_inc;
    logic [DATA_W-1:0] pc_out;
    // Pending-load scoreboard
    logic              pend_set;
    logic [ADDR_W-1:0] pend_addr;
    logic              hazard_n;
    logic              hazard_m;
    logic              hazard_s;
    logic              any_pending;

    modport master (
        output wr_en, wr_addr, wr_data,
        output rd_addr_n, rd_addr_m, rd_addr_s,
        input  rd_n, rd_m, rd_s,
        output pc_load, pc_in, pc_inc,
        input  pc_out,
        output pend_set, pend_addr,
        input  hazard_n, hazard_m, hazard_s, any_pending
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        input  rd_addr_n, rd_addr_m, rd_addr_s,
        output rd_n, rd_m, rd_s,
        input  pc_load, pc_in, pc_inc,
        output pc_out,
        input  pend_set, pend_addr,
        output hazard_n, hazard_m, hazard_s, any_pending
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Pending-load scoreboard: one bit per register, set when a load is issued,
// cleared when the register is written, looked up by all three read ports.
module rf_scoreboard #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int PC_IDX   = NUM_REGS - 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pend_set,
    input  logic [ADDR_W-1:0] pend_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ADDR_W-1:0] rd_addr_n,
    input  logic [ADDR_W-1:0] rd_addr_m,
    input  logic [ADDR_W-1:0] rd_addr_s,
    output logic              hazard_n,
    output logic              hazard_m,
    output logic              hazard_s,
    output logic              any_pending
);

    localparam logic [ADDR_W-1:0] PC_ADDR   = ADDR_W'(PC_IDX);
    localparam logic              BYPASS_EN = (BYPASS != 0);

    logic [NUM_REGS-1:0] pend;
    logic [NUM_REGS-1:0] pend_next;

    // Next pending vector: clear on write first, then set, so a load issued
    // in the same cycle as a write to the same register stays pending.
    always_comb begin
        // NOTE: start every always_comb from a full default so no path leaves
        // the output unassigned; a missing default infers a latch.
        pend_next = pend;
        if (wr_en) begin
            pend_next[wr_addr] = 1'b0;
        end
        if (pend_set && (pend_addr != PC_ADDR)) begin
            pend_next[pend_addr] = 1'b1;
        end
    end

    // Pending vector register; reset forgets every in-flight load.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend <= pend_next;
        end
    end

    // A hazard that the current write resolves (and forwards) is not flagged.
    assign hazard_n = pend[rd_addr_n] & ~(BYPASS_EN & wr_en & (wr_addr == rd_addr_n));
    assign hazard_m = pend[rd_addr_m] & ~(BYPASS_EN & wr_en & (wr_addr == rd_addr_m));
    assign hazard_s = pend[rd_addr_s] & ~(BYPASS_EN & wr_en & (wr_addr == rd_addr_s));

    assign any_pending = |pend;

endmodule

// File: rtl/regfile_banked_pc.sv
// General register file with three combinational read ports, one write port,
// a dedicated PC aliased at PC_IDX, optional write-to-read forwarding and a
// pending-load scoreboard feeding hazard flags to the control unit.
module regfile_banked_pc
    import rf_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int NUM_REGS     = DEF_NUM_REGS,
    parameter int ADDR_W       = $clog2(NUM_REGS),
    parameter int PC_IDX       = NUM_REGS - 1,
    parameter int PC_STEP      = DEF_PC_STEP,
    parameter int PC_READ_OFS  = DEF_PC_READ_OFS,
    parameter int RESET_VECTOR = DEF_RESET_VECTOR,
    parameter int BYPASS       = 1
) (
    input  logic                Clk,
    input  logic                RESET,
    regfile_banked_pc_if.slave  bus
);

    localparam logic [ADDR_W-1:0] PC_ADDR   = ADDR_W'(PC_IDX);
    localparam logic              BYPASS_EN = (BYPASS != 0);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] pc_rd;
    logic              wr_to_pc;

    logic [ADDR_W-1:0] rd_addr [3];
    logic [DATA_W-1:0] rd_data [3];

    assign wr_to_pc = bus.wr_en && (bus.wr_addr == PC_ADDR);

    // General register array; the slot at PC_IDX is never written.
    always_ff @(posedge Clk) begin
        if (!RESET) begin
            // NOTE: the array is cleared on reset because software may read
            // any register before writing it; this forces flops, not RAM.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.wr_en && !wr_to_pc) begin
            regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    // PC update, one action per cycle: branch write > load > increment > hold.
    always_ff @(posedge Clk) begin
        if (!RESET) begin
            pc <= DATA_W'(RESET_VECTOR);
        end else if (wr_to_pc) begin
            pc <= bus.wr_data;
        end else if (bus.pc_load) begin
            pc <= bus.pc_in;
        end else if (bus.pc_inc) begin
            pc <= pc + DATA_W'(PC_STEP);
        end
    end

    // Reads of the PC index see the current PC plus the read offset; a PC
    // write in the same cycle is deliberately not forwarded.
    assign pc_rd = DATA_W'(pc_read_value(64'(pc), 64'(PC_READ_OFS)));

    assign rd_addr[0] = bus.rd_addr_n;
    assign rd_addr[1] = bus.rd_addr_m;
    assign rd_addr[2] = bus.rd_addr_s;

    // Read muxes: PC alias, then same-cycle forwarding, then stored value.
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rd_data[p] = regs[rd_addr[p]];
            if (rd_addr[p] == PC_ADDR) begin
                rd_data[p] = pc_rd;
            end else if (BYPASS_EN && bus.wr_en && (bus.wr_addr == rd_addr[p])) begin
                rd_data[p] = bus.wr_data;
            end
        end
    end

    assign bus.rd_n   = rd_data[0];
    assign bus.rd_m   = rd_data[1];
    assign bus.rd_s   = rd_data[2];
    assign bus.pc_out = pc;

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .PC_IDX   (PC_IDX),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .clk         (Clk),
        .rst_n       (RESET),
        .pend_set    (bus.pend_set),
        .pend_addr   (bus.pend_addr),
        .wr_en       (bus.wr_en),
        .wr_addr     (bus.wr_addr),
        .rd_addr_n   (bus.rd_addr_n),
        .rd_addr_m   (bus.rd_addr_m),
        .rd_addr_s   (bus.rd_addr_s),
        .hazard_n    (bus.hazard_n),
        .hazard_m    (bus.hazard_m),
        .hazard_s    (bus.hazard_s),
        .any_pending (bus.any_pending)
    );

endmodule
